// File: rtl/axi_adapter_arb_32_pkg.sv
// Shared types for the 32-bit AXI adapter front-end arbiter.
package axi_adapter_arb_32_pkg;

  // Request kind understood by the adapter: single beat or full cache line.
  typedef enum logic {
    SINGLE_REQ     = 1'b0,
    CACHE_LINE_REQ = 1'b1
  } ad_req_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCKED   = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/axi_adapter_arb_32_rr.sv
// Combinational round-robin pick: first requester at or after the pointer,
// wrapping modulo NUM_REQ.
module rr_arb_tree_lite #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int             w_sum;
    logic [IDX_W-1:0] w_pos;
    o_valid = 1'b0;
    o_idx   = {IDX_W{1'b0}};
    w_sum   = 0;
    w_pos   = {IDX_W{1'b0}};
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      w_sum   = int'(i_ptr) + k;
      w_sum   = (w_sum >= int'(NUM_REQ)) ? (w_sum - int'(NUM_REQ)) : w_sum;
      w_pos   = IDX_W'(w_sum);
      o_valid = o_valid | i_req[w_pos];
      o_idx   = i_req[w_pos] ? w_pos : o_idx;
    end
  end

endmodule

// File: rtl/axi_adapter_arb_32.sv
// Round-robin front-end for the 32-bit AXI adapter: picks one cache-side
// requester, holds it until the adapter grants, and routes the single response back.
module axi_adapter_arb_32
  import axi_adapter_arb_32_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 3,
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned AXI_ID_WIDTH = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_PORTS-1:0]                  port_req_i,
  input  ad_req_t [NUM_PORTS-1:0]               port_type_i,
  input  logic [NUM_PORTS-1:0]                  port_we_i,
  input  logic [NUM_PORTS-1:0][31:0]            port_addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  port_wdata_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] port_be_i,
  input  logic [NUM_PORTS-1:0][1:0]             port_size_i,
  output logic [NUM_PORTS-1:0]                  port_gnt_o,
  output logic [NUM_PORTS-1:0]                  port_valid_o,
  output logic [DATA_WIDTH-1:0]                 port_rdata_o,
  output logic [NUM_PORTS-1:0]                  port_cw_valid_o,
  output logic [31:0]                           port_cw_o,
  output logic                                  adp_req_o,
  output ad_req_t                               adp_type_o,
  output logic                                  adp_we_o,
  output logic [31:0]                           adp_addr_o,
  output logic [DATA_WIDTH-1:0]                 adp_wdata_o,
  output logic [DATA_WIDTH/8-1:0]               adp_be_o,
  output logic [1:0]                            adp_size_o,
  output logic [AXI_ID_WIDTH-1:0]               adp_id_o,
  input  logic                                  adp_gnt_i,
  input  logic                                  adp_valid_i,
  input  logic [DATA_WIDTH-1:0]                 adp_rdata_i,
  input  logic [AXI_ID_WIDTH-1:0]               adp_id_i,
  input  logic [31:0]                           adp_cw_i,
  input  logic                                  adp_cw_valid_i,
  output logic                                  err_o
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_owner, w_owner_nxt;
  logic [IDX_W-1:0] r_rr, w_rr_nxt;
  logic             r_err, w_err_nxt;

  logic             w_pick_valid;
  logic [IDX_W-1:0] w_pick_idx;
  logic [IDX_W-1:0] w_sel;
  logic             w_req;
  logic [NUM_PORTS-1:0] w_gnt, w_valid, w_cw_valid;
  logic             w_unused_id;

  // Pointer arithmetic wraps at NUM_PORTS, which need not be a power of two.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] r;
    if (v == IDX_W'(NUM_PORTS - 1)) begin
      r = {IDX_W{1'b0}};
    end else begin
      r = v + IDX_W'(1'b1);
    end
    return r;
  endfunction

  rr_arb_tree_lite #(
    .NUM_REQ (NUM_PORTS),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req   (port_req_i),
    .i_ptr   (r_rr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // Next-state, port strobes and adapter request selection.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr;
    w_err_nxt   = r_err;
    w_sel       = r_owner;
    w_req       = 1'b0;
    w_gnt       = {NUM_PORTS{1'b0}};
    w_valid     = {NUM_PORTS{1'b0}};
    w_cw_valid  = {NUM_PORTS{1'b0}};
    case (r_state)
      IDLE: begin
        if (adp_valid_i || adp_cw_valid_i) begin
          w_err_nxt = 1'b1;
        end else begin
          w_err_nxt = r_err;
        end
        if (w_pick_valid) begin
          w_sel       = w_pick_idx;
          w_req       = 1'b1;
          w_owner_nxt = w_pick_idx;
          if (adp_gnt_i) begin
            w_gnt[w_pick_idx] = 1'b1;
            w_rr_nxt          = wrap_inc(w_pick_idx);
            w_state_nxt       = WAIT_RSP;
          end else begin
            w_state_nxt = LOCKED;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOCKED: begin
        // The adapter may already be sampling this request; never switch owner here.
        w_req = 1'b1;
        if (!port_req_i[r_owner] || adp_valid_i || adp_cw_valid_i) begin
          w_err_nxt = 1'b1;
        end else begin
          w_err_nxt = r_err;
        end
        if (adp_gnt_i) begin
          w_gnt[r_owner] = 1'b1;
          w_rr_nxt       = wrap_inc(r_owner);
          w_state_nxt    = WAIT_RSP;
        end else begin
          w_state_nxt = LOCKED;
        end
      end
      WAIT_RSP: begin
        if (adp_cw_valid_i) begin
          w_cw_valid[r_owner] = 1'b1;
        end else begin
          w_cw_valid = {NUM_PORTS{1'b0}};
        end
        if (adp_valid_i) begin
          w_valid[r_owner] = 1'b1;
          w_state_nxt      = IDLE;
          if (adp_id_i[IDX_W-1:0] != r_owner) begin
            w_err_nxt = 1'b1;
          end else begin
            w_err_nxt = r_err;
          end
        end else begin
          w_state_nxt = WAIT_RSP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Arbiter state; a reset drops any transaction in flight without completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_owner <= {IDX_W{1'b0}};
      r_rr    <= {IDX_W{1'b0}};
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_rr    <= w_rr_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign adp_req_o   = w_req;
  assign adp_type_o  = w_req ? port_type_i[w_sel] : SINGLE_REQ;
  assign adp_we_o    = w_req ? port_we_i[w_sel] : 1'b0;
  assign adp_addr_o  = w_req ? port_addr_i[w_sel] : 32'h0000_0000;
  assign adp_wdata_o = w_req ? port_wdata_i[w_sel] : {DATA_WIDTH{1'b0}};
  assign adp_be_o    = w_req ? port_be_i[w_sel] : {(DATA_WIDTH/8){1'b0}};
  assign adp_size_o  = w_req ? port_size_i[w_sel] : 2'b00;
  assign adp_id_o    = w_req ? AXI_ID_WIDTH'(w_sel) : {AXI_ID_WIDTH{1'b0}};

  assign port_gnt_o      = w_gnt;
  assign port_valid_o    = w_valid;
  assign port_cw_valid_o = w_cw_valid;
  assign port_rdata_o    = adp_rdata_i;
  assign port_cw_o       = adp_cw_i;
  assign err_o           = r_err;

  // Only the low ID bits identify the owner.
  assign w_unused_id = ^adp_id_i;

endmodule

// File: tb/tb_axi_adapter_arb_32.sv
// Directed bench for axi_adapter_arb_32 with hand-computed expectations.
module tb_axi_adapter_arb_32;
  import axi_adapter_arb_32_pkg::*;

  localparam int NP = 3;
  localparam int DW = 128;
  localparam int IW = 4;

  logic                     clk_i;
  logic                     rst_ni;
  logic [NP-1:0]            port_req_i;
  ad_req_t [NP-1:0]         port_type_i;
  logic [NP-1:0]            port_we_i;
  logic [NP-1:0][31:0]      port_addr_i;
  logic [NP-1:0][DW-1:0]    port_wdata_i;
  logic [NP-1:0][DW/8-1:0]  port_be_i;
  logic [NP-1:0][1:0]       port_size_i;
  logic [NP-1:0]            port_gnt_o;
  logic [NP-1:0]            port_valid_o;
  logic [DW-1:0]            port_rdata_o;
  logic [NP-1:0]            port_cw_valid_o;
  logic [31:0]              port_cw_o;
  logic                     adp_req_o;
  ad_req_t                  adp_type_o;
  logic                     adp_we_o;
  logic [31:0]              adp_addr_o;
  logic [DW-1:0]            adp_wdata_o;
  logic [DW/8-1:0]          adp_be_o;
  logic [1:0]               adp_size_o;
  logic [IW-1:0]            adp_id_o;
  logic                     adp_gnt_i;
  logic                     adp_valid_i;
  logic [DW-1:0]            adp_rdata_i;
  logic [IW-1:0]            adp_id_i;
  logic [31:0]              adp_cw_i;
  logic                     adp_cw_valid_i;
  logic                     err_o;

  int n_checks = 0;
  int n_fail   = 0;

  axi_adapter_arb_32 #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .port_req_i(port_req_i), .port_type_i(port_type_i), .port_we_i(port_we_i),
    .port_addr_i(port_addr_i), .port_wdata_i(port_wdata_i), .port_be_i(port_be_i),
    .port_size_i(port_size_i), .port_gnt_o(port_gnt_o), .port_valid_o(port_valid_o),
    .port_rdata_o(port_rdata_o), .port_cw_valid_o(port_cw_valid_o), .port_cw_o(port_cw_o),
    .adp_req_o(adp_req_o), .adp_type_o(adp_type_o), .adp_we_o(adp_we_o),
    .adp_addr_o(adp_addr_o), .adp_wdata_o(adp_wdata_o), .adp_be_o(adp_be_o),
    .adp_size_o(adp_size_o), .adp_id_o(adp_id_o), .adp_gnt_i(adp_gnt_i),
    .adp_valid_i(adp_valid_i), .adp_rdata_i(adp_rdata_i), .adp_id_i(adp_id_i),
    .adp_cw_i(adp_cw_i), .adp_cw_valid_i(adp_cw_valid_i), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq(tag, {103'd0, adp_req_o, port_gnt_o, port_valid_o, port_cw_valid_o, err_o,
                   adp_id_o, adp_we_o, adp_size_o, adp_type_o}, 128'd0);
  endtask

  initial begin
    int exp;
    rst_ni = 1'b0;
    port_req_i = '0; port_we_i = '0; adp_gnt_i = 1'b0; adp_valid_i = 1'b0;
    adp_cw_valid_i = 1'b0; adp_id_i = '0; adp_cw_i = 32'h0; adp_rdata_i = '0;
    for (int p = 0; p < NP; p++) begin
      port_type_i[p]  = SINGLE_REQ;
      port_addr_i[p]  = 32'h1000_0000 + 32'(p * 16);
      port_wdata_i[p] = {4{32'hA5A5_0000 + 32'(p)}};
      port_be_i[p]    = 16'hFFFF;
      port_size_i[p]  = 2'd2;
    end

    // 1: reset and idle with no requests
    tick; #1;
    check_quiet("reset_outputs");
    check_eq("reset_addr", {96'd0, adp_addr_o}, 128'd0);
    check_eq("reset_rdata", port_rdata_o, 128'd0);
    rst_ni = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick;
      check_quiet("idle_outputs");
    end

    // 2: all ports request, immediate grant, valid three cycles later
    port_req_i = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp = k % 3;
      adp_gnt_i = 1'b1; #1;
      check_eq("rr_req", {127'd0, adp_req_o}, 128'd1);
      check_eq("rr_id", {124'd0, adp_id_o}, 128'(exp));
      check_eq("rr_gnt", {125'd0, port_gnt_o}, 128'(1 << exp));
      check_eq("rr_addr", {96'd0, adp_addr_o}, 128'(32'h1000_0000 + 32'(exp * 16)));
      tick; adp_gnt_i = 1'b0; #1;
      check_eq("rr_wait_req", {124'd0, adp_req_o, port_gnt_o}, 128'd0);
      tick; tick;
      adp_valid_i = 1'b1; adp_id_i = IW'(exp); #1;
      check_eq("rr_valid", {125'd0, port_valid_o}, 128'(1 << exp));
      tick; adp_valid_i = 1'b0;
    end
    port_req_i = 3'b000;
    check_eq("rr_err", {127'd0, err_o}, 128'd0);

    // 3: port 1 line write held while adapter stalls, port 2 arrives mid-way
    port_req_i = 3'b010; port_we_i = 3'b010; port_type_i[1] = CACHE_LINE_REQ;
    port_wdata_i[1] = 128'h1111_2222_3333_4444_5555_6666_7777_8888; #1;
    check_eq("lock_first_req", {126'd0, adp_req_o, adp_we_o}, 128'd3);
    check_eq("lock_first_id", {124'd0, adp_id_o}, 128'd1);
    check_eq("lock_first_type", {127'd0, adp_type_o}, 128'(CACHE_LINE_REQ));
    check_eq("lock_first_gnt", {125'd0, port_gnt_o}, 128'd0);
    tick;
    for (int c = 1; c < 5; c++) begin
      if (c == 2) port_req_i = 3'b110;
      #1;
      check_eq("lock_addr", {96'd0, adp_addr_o}, 128'h1000_0010);
      check_eq("lock_wdata", adp_wdata_o, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
      check_eq("lock_gnt", {125'd0, port_gnt_o}, 128'd0);
      tick;
    end
    adp_gnt_i = 1'b1; #1;
    check_eq("lock_grant", {125'd0, port_gnt_o}, 128'b010);
    tick; adp_gnt_i = 1'b0; port_req_i = 3'b100; #1;
    check_eq("lock_wait_blocked", {124'd0, adp_req_o, port_gnt_o}, 128'd0);
    tick; adp_valid_i = 1'b1; adp_id_i = 4'd1; #1;
    check_eq("lock_valid", {125'd0, port_valid_o}, 128'b010);
    tick; adp_valid_i = 1'b0; adp_gnt_i = 1'b1; #1;
    check_eq("lock_next_id", {124'd0, adp_id_o}, 128'd2);
    check_eq("lock_next_gnt", {125'd0, port_gnt_o}, 128'b100);
    tick; adp_gnt_i = 1'b0; port_req_i = 3'b000; port_we_i = 3'b000;
    tick; adp_valid_i = 1'b1; adp_id_i = 4'd2; #1;
    check_eq("lock_next_valid", {125'd0, port_valid_o}, 128'b100);
    tick; adp_valid_i = 1'b0; #1;
    check_eq("lock_err", {127'd0, err_o}, 128'd0);

    // 4: port 0 line read with critical word on second beat
    port_req_i = 3'b001; port_type_i[0] = CACHE_LINE_REQ; adp_gnt_i = 1'b1; #1;
    check_eq("cw_gnt", {125'd0, port_gnt_o}, 128'b001);
    tick; adp_gnt_i = 1'b0; port_req_i = 3'b000; #1;
    check_eq("cw_beat1", {125'd0, port_cw_valid_o}, 128'd0);
    tick; adp_cw_valid_i = 1'b1; adp_cw_i = 32'hDEAD_BEEF; #1;
    check_eq("cw_valid", {125'd0, port_cw_valid_o}, 128'b001);
    check_eq("cw_word", {96'd0, port_cw_o}, 128'hDEAD_BEEF);
    tick; adp_cw_valid_i = 1'b0; #1;
    check_eq("cw_once", {125'd0, port_cw_valid_o}, 128'd0);
    tick; tick;
    adp_valid_i = 1'b1; adp_id_i = 4'd0; adp_rdata_i = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; #1;
    check_eq("line_valid", {125'd0, port_valid_o}, 128'b001);
    check_eq("line_rdata", port_rdata_o, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    tick; adp_valid_i = 1'b0; #1;
    check_eq("line_valid_once", {125'd0, port_valid_o}, 128'd0);
    check_eq("line_err", {127'd0, err_o}, 128'd0);

    // 5a: response ID mismatch still routes to owner 0 but flags an error
    port_req_i = 3'b001; port_type_i[0] = SINGLE_REQ; adp_gnt_i = 1'b1;
    tick; adp_gnt_i = 1'b0; port_req_i = 3'b000;
    adp_valid_i = 1'b1; adp_id_i = 4'd2; #1;
    check_eq("badid_route", {125'd0, port_valid_o}, 128'b001);
    tick; adp_valid_i = 1'b0; adp_id_i = 4'd0; #1;
    check_eq("badid_err", {127'd0, err_o}, 128'd1);
    rst_ni = 1'b0; #1;
    check_eq("err_reset", {127'd0, err_o}, 128'd0);
    tick; rst_ni = 1'b1;

    // 5b: stray completion while idle
    adp_valid_i = 1'b1; #1;
    check_eq("stray_no_pulse", {125'd0, port_valid_o}, 128'd0);
    tick; adp_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("stray_err_sticky", {127'd0, err_o}, 128'd1);
      tick;
    end

    // 6: reset during WAIT_RSP, then port 0 wins again
    port_req_i = 3'b001; adp_gnt_i = 1'b1;
    tick; adp_gnt_i = 1'b0; port_req_i = 3'b000; adp_cw_valid_i = 1'b1; #1;
    check_eq("rst_pre_cw", {125'd0, port_cw_valid_o}, 128'b001);
    rst_ni = 1'b0; #1;
    check_eq("rst_cw_zero", {125'd0, port_cw_valid_o}, 128'd0);
    check_quiet("rst_outputs");
    adp_cw_valid_i = 1'b0;
    tick; tick; rst_ni = 1'b1;
    tick; port_req_i = 3'b111; #1;
    check_eq("rst_winner_req", {127'd0, adp_req_o}, 128'd1);
    check_eq("rst_winner_id", {124'd0, adp_id_o}, 128'd0);
    port_req_i = 3'b000;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
